fetch_stage: RTL and testbench

//  Instruction-fetch stage sitting directly upstream of the instruction block_ram (IMEM_MODE=1).

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_ifid_reg.sv | 39 +++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// State encoding, word width and the default NOP word.
package fetch_pkg;

    localparam int XLEN = 16;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_WORD = 16'h0020;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID output register: load, flush and hold controls.
// Holds the fetched word and its PC until decode takes it.
module fetch_ifid_reg
    import fetch_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_WORD
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  flush_i,
    input  logic  ready_i,
    input  word_t instr_i,
    input  word_t pc_i,
    output logic  valid_o,
    output word_t instr_o,
    output word_t pc_o
);

    // Flush beats load; an accepted word with no refill empties the slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            instr_o <= NOP_INSTR;
            pc_o    <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            instr_o <= NOP_INSTR;
        end else if (load_i) begin
            valid_o <= 1'b1;
            instr_o <= instr_i;
            pc_o    <= pc_i;
        end else if (ready_i) begin
            valid_o <= 1'b0;
            instr_o <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage in front of a same-cycle IMEM.
// Owns the PC, the fetch FSM and the accepted-instruction count.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter word_t PC_RESET    = 16'h0000,
    parameter int    NUM_ENTRIES = 256,
    parameter word_t NOP_INSTR   = NOP_WORD
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] imem_addr_o,
    input  logic [15:0] imem_rdata_i,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        valid_o,
    output logic [15:0] instr_o,
    output logic [15:0] pc_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [15:0] fetch_count_o
);

    localparam logic [16:0] LIMIT = 17'(NUM_ENTRIES);

    state_t state_q, state_d;
    word_t  pc_q, pc_d;
    logic   in_range;
    logic   load;
    logic   flush;
    logic   accept;

    assign in_range    = {1'b0, pc_q} < LIMIT;
    assign imem_addr_o = pc_q;
    assign halted_o    = (state_q == S_HALT);
    assign fault_o     = (state_q == S_FAULT);
    assign accept      = valid_o & ready_i & ~flush;

    // Next state, next PC and output-register controls.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                unique case (1'b1)
                    halt_i: begin
                        state_d = S_HALT;
                        flush   = 1'b1;
                    end
                    !halt_i && redirect_i: begin
                        pc_d  = redirect_pc_i;
                        flush = 1'b1;
                    end
                    !halt_i && !redirect_i && !in_range: begin
                        state_d = S_FAULT;
                    end
                    default: begin
                        if (!valid_o || ready_i) begin
                            load = 1'b1;
                            pc_d = pc_q + 16'd1;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_BOOT;
            pc_q    <= PC_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Saturating count of words handed to decode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_count_o <= '0;
        end else if (accept && fetch_count_o != 16'hFFFF) begin
            fetch_count_o <= fetch_count_o + 16'd1;
        end
    end

    fetch_ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load),
        .flush_i (flush),
        .ready_i (ready_i),
        .instr_i (imem_rdata_i),
        .pc_i    (pc_q),
        .valid_o (valid_o),
        .instr_o (instr_o),
        .pc_o    (pc_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage with a behavioural IMEM and reference model.
// A second instance with an 8-word IMEM covers the range fault.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0020;
    localparam logic [15:0] PCR = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;

    logic [15:0] addr, rdata, instr, pc_o, count;
    logic        valid, halted, fault;
    logic [15:0] f_addr, f_rdata, f_instr, f_pc, f_count;
    logic        f_valid, f_halted, f_fault;

    logic [15:0] imem [256];

    int vectors = 0;
    int errors  = 0;

    int          m_phase;
    logic [15:0] m_pc, m_instr, m_pco, m_count;
    logic        m_valid;

    assign rdata   = imem[addr[7:0]];
    assign f_rdata = imem[f_addr[7:0]];

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_RESET(PCR), .NUM_ENTRIES(256), .NOP_INSTR(NOP)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_addr_o(addr), .imem_rdata_i(rdata),
        .ready_i(ready), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .halt_i(halt),
        .valid_o(valid), .instr_o(instr), .pc_o(pc_o),
        .halted_o(halted), .fault_o(fault),
        .fetch_count_o(count)
    );

    fetch_stage #(
        .PC_RESET(PCR), .NUM_ENTRIES(8), .NOP_INSTR(NOP)
    ) dut_f (
        .clk_i(clk), .rst_i(rst),
        .imem_addr_o(f_addr), .imem_rdata_i(f_rdata),
        .ready_i(ready), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .halt_i(halt),
        .valid_o(f_valid), .instr_o(f_instr), .pc_o(f_pc),
        .halted_o(f_halted), .fault_o(f_fault),
        .fetch_count_o(f_count)
    );

    // Reference: 0 boot, 1 run, 2 halt, 3 fault; one call per edge.
    task automatic model_step();
        bit take;
        bit kill;
        if (rst) begin
            m_phase = 0;
            m_pc    = PCR;
            m_valid = 0;
            m_instr = NOP;
            m_pco   = 0;
            m_count = 0;
            return;
        end
        kill = (m_phase == 1) && (halt || redirect);
        if (m_valid && ready && !kill && m_count != 16'hFFFF)
            m_count = m_count + 1;
        take = 0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (halt) m_phase = 2;
            else if (redirect) m_pc = redirect_pc;
            else if (int'(m_pc) >= 256) m_phase = 3;
            else take = !m_valid || ready;
        end
        if (kill) begin
            m_valid = 0;
            m_instr = NOP;
        end else if (take) begin
            m_instr = imem[m_pc[7:0]];
            m_pco   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 16'd1;
        end else if (ready) begin
            m_valid = 0;
            m_instr = NOP;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; ready = 1; redirect = 0; halt = 0;
        redirect_pc = 0;
        tick();
        rst = 0;
    endtask

    task automatic run_to(input logic [15:0] t, output bit ok);
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            ok = valid && pc_o == t;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({valid, halted, fault} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags: got %b want 000",
                     {valid, halted, fault});
        end
        vectors++;
        if ({instr, pc_o, count, addr} !== {NOP, 48'h0}) begin
            errors++;
            $display("FAIL rst_regs: got %h %h %h %h want 0020 0 0 0",
                     instr, pc_o, count, addr);
        end
        tick();
        vectors++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_valid: got %b want 0", valid);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (valid !== 1'b1 || pc_o !== 16'(k) ||
                instr !== imem[k]) begin
                errors++;
                $display("FAIL seq_%0d: got v=%b pc=%h i=%h want 1 %h %h",
                         k, valid, pc_o, instr, 16'(k), imem[k]);
            end
        end
        vectors++;
        if (count !== 16'd9) begin
            errors++;
            $display("FAIL seq_count: got %0d want 9", count);
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        run_to(16'd5, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_reach: got pc=%h want 0005", pc_o);
        end
        ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({valid, pc_o, instr, addr} !==
                {1'b1, 16'd5, imem[5], 16'd6}) begin
                errors++;
                $display("FAIL stall_%0d: got %b %h %h %h want 1 5 %h 6",
                         k, valid, pc_o, instr, addr, imem[5]);
            end
        end
        ready = 1;
        tick();
        vectors++;
        if (valid !== 1'b1 || pc_o !== 16'd6 || instr !== imem[6]) begin
            errors++;
            $display("FAIL stall_resume: got %b %h %h want 1 6 %h",
                     valid, pc_o, instr, imem[6]);
        end
    endtask

    task automatic test_redirect();
        bit ok;
        logic [15:0] c0;
        do_reset();
        run_to(16'd3, ok);
        ready = 0;
        redirect = 1;
        redirect_pc = 16'h0010;
        c0 = count;
        tick();
        redirect = 0;
        vectors++;
        if ({valid, instr, addr, count} !==
            {1'b0, NOP, 16'h0010, c0}) begin
            errors++;
            $display("FAIL redir_flush: got %b %h %h %0d want 0 0020 0010 %0d",
                     valid, instr, addr, count, c0);
        end
        ready = 1;
        tick();
        vectors++;
        if ({valid, pc_o, instr, count} !==
            {1'b1, 16'h0010, imem[16], c0}) begin
            errors++;
            $display("FAIL redir_target: got %b %h %h %0d want 1 0010 %h %0d",
                     valid, pc_o, instr, count, imem[16], c0);
        end
    endtask

    task automatic test_halt();
        bit ok;
        do_reset();
        run_to(16'd4, ok);
        halt = 1;
        redirect = 1;
        redirect_pc = 16'h0040;
        tick();
        halt = 0;
        redirect = 0;
        vectors++;
        if ({halted, valid, instr, addr} !==
            {1'b1, 1'b0, NOP, 16'd5}) begin
            errors++;
            $display("FAIL halt_enter: got %b %b %h %h want 1 0 0020 0005",
                     halted, valid, instr, addr);
        end
        for (int k = 0; k < 4; k++) begin
            ready = 1'($urandom_range(0, 1));
            redirect = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if ({halted, valid, addr} !== {1'b1, 1'b0, 16'd5}) begin
                errors++;
                $display("FAIL halt_hold_%0d: got %b %b %h want 1 0 0005",
                         k, halted, valid, addr);
            end
        end
        redirect = 0;
        ready = 1;
    endtask

    task automatic test_fault();
        do_reset();
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if ({f_valid, f_pc, f_fault} !== {1'b1, 16'(k), 1'b0}) begin
                errors++;
                $display("FAIL flt_seq_%0d: got %b %h %b want 1 %h 0",
                         k, f_valid, f_pc, f_fault, 16'(k));
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({f_fault, f_valid, f_addr, f_instr, f_halted} !==
                {1'b1, 1'b0, 16'd8, NOP, 1'b0}) begin
                errors++;
                $display("FAIL flt_hold_%0d: got %b %b %h %h %b want 1 0 8 0020 0",
                         k, f_fault, f_valid, f_addr, f_instr, f_halted);
            end
        end
        vectors++;
        if (f_count !== 16'd8) begin
            errors++;
            $display("FAIL flt_count: got %0d want 8", f_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        run_to(16'd12, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_reach: got pc=%h want 000c", pc_o);
        end
        rst = 1;
        tick();
        rst = 0;
        vectors++;
        if ({valid, instr, pc_o, count, addr, halted, fault} !==
            {1'b0, NOP, 48'h0, 2'b00}) begin
            errors++;
            $display("FAIL mid_rst: got %b %h %h %h %h want 0 0020 0 0 0",
                     valid, instr, pc_o, count, addr);
        end
        tick();
        tick();
        vectors++;
        if (valid !== 1'b1 || pc_o !== PCR || instr !== imem[0]) begin
            errors++;
            $display("FAIL mid_restart: got %b %h %h want 1 0000 %h",
                     valid, pc_o, instr, imem[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 11) == 0);
            halt = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 9) == 0)
                redirect_pc = 16'($urandom_range(250, 300));
            else
                redirect_pc = 16'($urandom_range(0, 255));
            tick();
            vectors++;
            if ({valid, instr, pc_o, count, addr, halted, fault} !==
                {m_valid, m_instr, m_pco, m_count, m_pc,
                 m_phase == 2, m_phase == 3}) begin
                errors++;
                $display("FAIL rand_%0d: got %b %h %h %h %h %b%b want %b %h %h %h %h %b%b",
                         n, valid, instr, pc_o, count, addr, halted, fault,
                         m_valid, m_instr, m_pco, m_count, m_pc,
                         m_phase == 2, m_phase == 3);
            end
        end
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
        rst = 1; ready = 1; redirect = 0; halt = 0;
        redirect_pc = 0;
        #2;
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
